// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared constants for the multiplexed 7-segment display
//                driver: code width, special codes and logical glyph on-sets
//                packed as {g,f,e,d,c,b,a}.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    localparam int CODE_W = 5;

    localparam logic [CODE_W-1:0] CODE_MINUS = 5'd16;
    localparam logic [CODE_W-1:0] CODE_BLANK = 5'd31;

    //                                   gfedcba
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b1111100;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;
    localparam logic [6:0] SEG_MINUS = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // A code that lights nothing (zero or any code above the minus glyph)
    // still counts as "leading" for zero suppression of lower digits.
    function automatic logic is_blank_or_zero(input logic [CODE_W-1:0] code);
        return (code == '0) || (code > CODE_MINUS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational 5-bit display code to logical segment on-set
//                ({g,f,e,d,c,b,a}, 1 = lit). Pin polarity is applied by the
//                caller.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import display_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [6:0]        segs
);

    // Glyph lookup: hex digits, minus, everything else dark
    always_comb begin
        segs = SEG_BLANK;
        case (code)
            5'd0:       segs = SEG_0;
            5'd1:       segs = SEG_1;
            5'd2:       segs = SEG_2;
            5'd3:       segs = SEG_3;
            5'd4:       segs = SEG_4;
            5'd5:       segs = SEG_5;
            5'd6:       segs = SEG_6;
            5'd7:       segs = SEG_7;
            5'd8:       segs = SEG_8;
            5'd9:       segs = SEG_9;
            5'd10:      segs = SEG_A;
            5'd11:      segs = SEG_B;
            5'd12:      segs = SEG_C;
            5'd13:      segs = SEG_D;
            5'd14:      segs = SEG_E;
            5'd15:      segs = SEG_F;
            CODE_MINUS: segs = SEG_MINUS;
            default:    segs = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/display_7s_mux.sv
`default_nettype none
// ============================================================================
//  Module      : display_7s_mux
//  Description : Time-multiplexed N-digit 7-segment driver with per-slot
//                anti-ghost blanking, frame snapshot, optional leading-zero
//                suppression and configurable pin polarity.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_7s_mux
    import display_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int CLK_DIV     = 50000,
    parameter int BLANK_CYC   = 16,
    parameter int ACTIVE_LOW  = 1,
    parameter int LZ_SUPPRESS = 0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [CODE_W*DIGITS-1:0] codes,
    input  logic [DIGITS-1:0]        dps,
    output logic [6:0]               seg,
    output logic                     dp,
    output logic [DIGITS-1:0]        an,
    output logic                     frame_start
);

    localparam int c_PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(CLK_DIV - 1);
    localparam logic [c_PRESC_W-1:0] c_BLANK_END = c_PRESC_W'(BLANK_CYC);
    localparam logic [c_IDX_W-1:0]   c_IDX_MAX   = c_IDX_W'(DIGITS - 1);
    localparam logic                 c_INV       = (ACTIVE_LOW != 0);
    localparam logic                 c_LZ        = (LZ_SUPPRESS != 0);

    logic [c_PRESC_W-1:0]     r_presc;
    logic [c_IDX_W-1:0]       r_idx;
    logic [CODE_W*DIGITS-1:0] r_codes;
    logic [DIGITS-1:0]        r_dps;

    // Output registers hold logical (1 = lit) values so reset means dark
    logic [DIGITS-1:0]        r_an;
    logic [6:0]               r_seg;
    logic                     r_dp;
    logic                     r_frame_start;

    logic                     w_tick;
    logic                     w_wrap;
    logic                     w_an_on;
    logic [DIGITS-1:0]        w_suppress;
    logic [DIGITS-1:0]        w_onehot;
    logic [CODE_W-1:0]        w_code;
    logic                     w_dp_sel;
    logic                     w_sup_sel;
    logic [6:0]               w_glyph;

    assign w_tick  = enable && (r_presc == c_PRESC_MAX);
    assign w_wrap  = w_tick && (r_idx == c_IDX_MAX);
    assign w_an_on = enable && (r_presc >= c_BLANK_END);

    // Slot prescaler and digit index; both freeze while disabled
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (enable) begin
            if (w_tick) begin
                r_presc <= '0;
                r_idx   <= (r_idx == c_IDX_MAX) ? '0 : r_idx + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // Frame snapshot: inputs are sampled only as the scan returns to digit 0
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_codes <= '0;
            r_dps   <= '0;
        end else if (w_wrap) begin
            r_codes <= codes;
            r_dps   <= dps;
        end
    end

    // Leading-zero mask, walked from the most significant digit downward
    always_comb begin : lz_mask
        logic v_lead;
        w_suppress = '0;
        v_lead     = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_suppress[i] = c_LZ && v_lead && (r_codes[CODE_W*i +: CODE_W] == '0);
            v_lead        = v_lead && is_blank_or_zero(r_codes[CODE_W*i +: CODE_W]);
        end
    end

    // Select the active digit's code, decimal point, mask bit and anode
    always_comb begin
        w_code    = '0;
        w_dp_sel  = 1'b0;
        w_sup_sel = 1'b0;
        w_onehot  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_code      = r_codes[CODE_W*i +: CODE_W];
                w_dp_sel    = r_dps[i];
                w_sup_sel   = w_suppress[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    seg7_decode u_decode (
        .code (w_code),
        .segs (w_glyph)
    );

    // Registered outputs; segments and dp go dark whenever the anode is off
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_an          <= '0;
            r_seg         <= '0;
            r_dp          <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_wrap;
            if (w_an_on) begin
                r_an  <= w_onehot;
                r_seg <= w_sup_sel ? SEG_BLANK : w_glyph;
                r_dp  <= w_dp_sel;
            end else begin
                r_an  <= '0;
                r_seg <= '0;
                r_dp  <= 1'b0;
            end
        end
    end

    assign an          = r_an ^ {DIGITS{c_INV}};
    assign seg         = r_seg ^ {7{c_INV}};
    assign dp          = r_dp ^ c_INV;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_display_7s_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_7s_mux
//  Description : Directed bench for display_7s_mux (4 digits, 4-cycle slots,
//                1 blanking cycle, active-low pins), with and without
//                leading-zero suppression.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_7s_mux;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [19:0] codes;
    logic [3:0]  dps;
    logic [6:0]  seg,   seg_lz;
    logic        dp,    dp_lz;
    logic [3:0]  an,    an_lz;
    logic        frame_start, fs_lz;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    display_7s_mux #(.DIGITS(4), .CLK_DIV(4), .BLANK_CYC(1), .ACTIVE_LOW(1), .LZ_SUPPRESS(0)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .codes(codes), .dps(dps),
        .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
    );

    display_7s_mux #(.DIGITS(4), .CLK_DIV(4), .BLANK_CYC(1), .ACTIVE_LOW(1), .LZ_SUPPRESS(1)) dut_lz (
        .clock(clock), .reset_n(reset_n), .enable(enable), .codes(codes), .dps(dps),
        .seg(seg_lz), .dp(dp_lz), .an(an_lz), .frame_start(fs_lz)
    );

    typedef struct {
        logic [19:0]     codes;
        logic [3:0]      dps;
        logic [3:0][6:0] es;   // expected pins per digit, no suppression
        logic [3:0][6:0] el;   // expected pins per digit, with suppression
    } vec_t;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] PB = 7'b1111111;

    vec_t vecs[5];
    vec_t vzero;
    vec_t v1;
    vec_t v9;

    function automatic logic [19:0] mk(input logic [4:0] c3, input logic [4:0] c2,
                                       input logic [4:0] c1, input logic [4:0] c0);
        return {c3, c2, c1, c0};
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s k=%0d actual=%h required=%h", nm, k, act, req);
        end
    endtask

    // k counts sampled cycles from frame start; outputs lag the counter by one
    task automatic check_cycle(input int k, input vec_t v);
        int         pos;
        int         d;
        logic [3:0] ean;
        logic [6:0] es;
        logic [6:0] el;
        logic       edp;
        pos = k - 1;
        d   = pos / 4;
        ean = 4'hF; es = PB; el = PB; edp = 1'b1;
        if ((pos % 4) != 0) begin
            ean[d] = 1'b0;
            es     = v.es[d];
            el     = v.el[d];
            edp    = ~v.dps[d];
        end
        chk("an",        k, an,     ean);
        chk("seg",       k, seg,    es);
        chk("dp",        k, dp,     edp);
        chk("an_lz",     k, an_lz,  ean);
        chk("seg_lz",    k, seg_lz, el);
        chk("dp_lz",     k, dp_lz,  edp);
        chk("frame",     k, frame_start, (k == 16));
        chk("frame_lz",  k, fs_lz,       (k == 16));
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!frame_start && n < 40);
        chk("frame_wait", n, frame_start, 1);
    endtask

    task automatic run_frame(input vec_t v, input int change_k, input logic [19:0] new_codes);
        wait_frame();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            check_cycle(k, v);
            if (k == change_k) codes = new_codes;
        end
    endtask

    initial begin
        vzero = '{codes: '0, dps: 4'b0000, es: {P0, P0, P0, P0}, el: {PB, PB, PB, P0}};
        v1    = '{codes: mk(1, 2, 3, 8), dps: 4'b0100,
                  es: {7'b1111001, 7'b0100100, 7'b0110000, 7'b0000000},
                  el: {7'b1111001, 7'b0100100, 7'b0110000, 7'b0000000}};
        v9    = '{codes: mk(1, 2, 9, 8), dps: 4'b0100,
                  es: {7'b1111001, 7'b0100100, 7'b0010000, 7'b0000000},
                  el: {7'b1111001, 7'b0100100, 7'b0010000, 7'b0000000}};
        vecs[0] = vzero;
        vecs[1] = v1;
        vecs[2] = '{codes: mk(10, 15, 16, 20), dps: 4'b0001,
                    es: {7'b0001000, 7'b0001110, 7'b0111111, PB},
                    el: {7'b0001000, 7'b0001110, 7'b0111111, PB}};
        vecs[3] = '{codes: mk(0, 0, 4, 0), dps: 4'b1100,
                    es: {P0, P0, 7'b0011001, P0},
                    el: {PB, PB, 7'b0011001, P0}};
        vecs[4] = '{codes: mk(20, 0, 0, 5), dps: 4'b0000,
                    es: {PB, P0, P0, 7'b0010010},
                    el: {PB, PB, PB, 7'b0010010}};

        // Reset with non-zero inputs present: first frame must still show zeros
        reset_n = 1'b0;
        enable  = 1'b1;
        codes   = mk(8, 8, 8, 8);
        dps     = 4'hF;
        repeat (3) @(negedge clock);
        chk("rst_an",    0, an,          4'hF);
        chk("rst_seg",   0, seg,         PB);
        chk("rst_dp",    0, dp,          1'b1);
        chk("rst_frame", 0, frame_start, 1'b0);
        chk("rst_an_lz", 0, an_lz,       4'hF);
        reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            check_cycle(k, vzero);
        end

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            codes = vecs[i].codes;
            dps   = vecs[i].dps;
            run_frame(vecs[i], 0, '0);
        end

        // Mid-frame input change stays invisible until the next snapshot
        codes = v1.codes;
        dps   = v1.dps;
        run_frame(v1, 6, v9.codes);
        run_frame(v9, 0, '0);

        // Enable dropped mid-slot for 10 cycles, then resumed
        wait_frame();
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            check_cycle(k, v9);
        end
        enable = 1'b0;
        for (int k = 7; k <= 16; k++) begin
            @(negedge clock);
            chk("dis_an",    k, an,          4'hF);
            chk("dis_seg",   k, seg,         PB);
            chk("dis_dp",    k, dp,          1'b1);
            chk("dis_frame", k, frame_start, 1'b0);
        end
        enable = 1'b1;
        @(negedge clock);
        chk("resume_an",  17, an,  4'hD);
        chk("resume_seg", 17, seg, 7'b0010000);
        @(negedge clock);
        chk("resume_an",  18, an,  4'hD);
        @(negedge clock);
        chk("resume_an",  19, an,  4'hF);
        @(negedge clock);
        chk("resume_an",  20, an,  4'hB);
        chk("resume_seg", 20, seg, 7'b0100100);

        // Asynchronous reset mid-slot darkens outputs without a clock edge
        @(posedge clock);
        #2;
        chk("pre_areset_an", 21, an, 4'hB);
        reset_n = 1'b0;
        #1;
        chk("areset_an",    21, an,    4'hF);
        chk("areset_seg",   21, seg,   PB);
        chk("areset_dp",    21, dp,    1'b1);
        chk("areset_an_lz", 21, an_lz, 4'hF);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            check_cycle(k, vzero);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
